// File: rtl/wb_trace_monitor.sv
// Write-back trace unit: shadows the register file, logs filtered writes with cycle stamp and PC
// into a show-ahead FIFO, and can dump the whole shadow file through the same valid/ready stream.
module wb_trace_monitor #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int DEPTH = 16,
   parameter int CYC_W = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wb_en,
   input  logic [$clog2(NREG)-1:0]    wb_rd,
   input  logic [XLEN-1:0]            wb_data,
   input  logic [XLEN-1:0]            wb_pc,
   input  logic                       cfg_mode,
   input  logic [NREG-1:0]            cfg_mask,
   input  logic                       snap_req,
   output logic                       snap_busy,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_kind,
   output logic [CYC_W-1:0]           out_cycle,
   output logic [XLEN-1:0]            out_pc,
   output logic [$clog2(NREG)-1:0]    out_rd,
   output logic [XLEN-1:0]            out_data,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic [15:0]                drop_count,
   output logic                       o_dbg_state
);

   localparam int RW = $clog2(NREG);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {IDLE = 1'b0, DUMP = 1'b1} state_t;

   typedef struct packed {
      logic             kind;
      logic [CYC_W-1:0] cycle;
      logic [XLEN-1:0]  pc;
      logic [RW-1:0]    rd;
      logic [XLEN-1:0]  data;
   } entry_t;

   logic [CYC_W-1:0] r_cycle;
   logic [XLEN-1:0]  r_shadow [NREG];
   entry_t           r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic [15:0]      r_drop;
   state_t           r_state;
   logic [RW-1:0]    r_idx;

   state_t           w_next_state;
   logic [RW-1:0]    w_next_idx;
   logic             w_snap_push;
   logic             w_ev;
   logic             w_full;
   logic             w_pop;
   logic             w_space;
   logic             w_ev_push;
   logic             w_drop;
   logic             w_push;
   entry_t           w_push_entry;
   entry_t           w_head;

   // Stream: an entry transfers on a clock edge where out_valid && out_ready; while out_valid=1 and
   // out_ready=0 the head entry is held stable.
   assign w_head     = r_mem[r_rd_ptr];
   assign out_valid  = (r_level != '0);
   assign out_kind   = w_head.kind;
   assign out_cycle  = w_head.cycle;
   assign out_pc     = w_head.pc;
   assign out_rd     = w_head.rd;
   assign out_data   = w_head.data;
   assign fifo_level = r_level;
   assign drop_count = r_drop;
   assign snap_busy  = (r_state == DUMP);
   assign o_dbg_state = r_state;

   // Change detection compares against the shadow value before this cycle's update.
   assign w_ev = wb_en && (wb_rd != '0) && cfg_mask[wb_rd] &&
                 (!cfg_mode || (wb_data != r_shadow[wb_rd]));

   assign w_full    = (r_level == LW'(DEPTH));
   assign w_pop     = out_valid && out_ready;
   assign w_space   = !w_full || w_pop;
   assign w_ev_push = w_ev && w_space;
   assign w_drop    = w_ev && !w_space;
   assign w_push    = w_ev_push || w_snap_push;

   always_comb begin
      w_push_entry = '0;
      if (w_ev_push) begin
         w_push_entry.kind  = 1'b0;
         w_push_entry.cycle = r_cycle;
         w_push_entry.pc    = wb_pc;
         w_push_entry.rd    = wb_rd;
         w_push_entry.data  = wb_data;
      end else begin
         w_push_entry.kind  = 1'b1;
         w_push_entry.cycle = r_cycle;
         w_push_entry.pc    = '0;
         w_push_entry.rd    = r_idx;
         w_push_entry.data  = r_shadow[r_idx];
      end
   end

   // Write events take the push slot first; the dump simply stalls and never drops.
   always_comb begin
      w_next_state = r_state;
      w_next_idx   = r_idx;
      w_snap_push  = 1'b0;
      case (r_state)
         IDLE: begin
            if (snap_req) begin
               w_next_state = DUMP;
               w_next_idx   = '0;
            end
         end
         DUMP: begin
            if (!w_ev && w_space) begin
               w_snap_push = 1'b1;
               w_next_idx  = r_idx + RW'(1);
               if (r_idx == RW'(NREG - 1)) begin
                  w_next_state = IDLE;
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_next_state;
         r_idx   <= w_next_idx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycle <= '0;
         for (int i = 0; i < NREG; i++) begin
            r_shadow[i] <= '0;
         end
      end else begin
         r_cycle <= r_cycle + CYC_W'(1);
         if (wb_en && (wb_rd != '0)) begin
            r_shadow[wb_rd] <= wb_data;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_drop   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         if (w_drop && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 16'd1;
         end
      end
   end

   // Payload storage needs no reset: it is only observed while out_valid=1.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_push_entry;
      end
   end

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Directed self-checking bench for wb_trace_monitor: logging, filtering, overflow, snapshot dump
// and reset in the middle of a dump. Inputs change and outputs are sampled on the falling edge.
module tb_wb_trace_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [31:0] wb_pc;
   logic        cfg_mode;
   logic [31:0] cfg_mask;
   logic        snap_req;
   logic        snap_busy;
   logic        out_valid;
   logic        out_ready;
   logic        out_kind;
   logic [31:0] out_cycle;
   logic [31:0] out_pc;
   logic [4:0]  out_rd;
   logic [31:0] out_data;
   logic [4:0]  fifo_level;
   logic [15:0] drop_count;
   logic        dbg_state;

   int checks = 0;
   int errors = 0;
   logic [31:0] tb_cyc;

   wb_trace_monitor #(.XLEN(32), .NREG(32), .DEPTH(16), .CYC_W(32)) dut (
      .clk(clk), .reset(reset), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
      .cfg_mode(cfg_mode), .cfg_mask(cfg_mask), .snap_req(snap_req), .snap_busy(snap_busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_cycle(out_cycle),
      .out_pc(out_pc), .out_rd(out_rd), .out_data(out_data), .fifo_level(fifo_level),
      .drop_count(drop_count), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Reference cycle count: zero in reset, +1 on every rising edge afterwards.
   always @(posedge clk or posedge reset) begin
      if (reset) tb_cyc <= 32'd0;
      else       tb_cyc <= tb_cyc + 32'd1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   task automatic drive_write(input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc);
      wb_en = 1'b1; wb_rd = rd; wb_data = data; wb_pc = pc;
      @(negedge clk);
      wb_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; wb_en = 1'b0; wb_rd = '0; wb_data = '0; wb_pc = '0;
      cfg_mode = 1'b0; cfg_mask = '1; snap_req = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
      checks++; if (snap_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", snap_busy); end
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
      checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
      checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %0b want 0", dbg_state); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      logic [31:0] exp_cyc;
      cfg_mode = 1'b0; cfg_mask = '1; out_ready = 1'b1;
      exp_cyc = tb_cyc;
      drive_write(5'd5, 32'h0000_00AA, 32'h8);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
      checks++; if (out_kind !== 1'b0) begin errors++; $display("FAIL basic_kind: got %0b want 0", out_kind); end
      checks++; if (out_rd !== 5'd5) begin errors++; $display("FAIL basic_rd: got %0d want 5", out_rd); end
      checks++; if (out_data !== 32'hAA) begin errors++; $display("FAIL basic_data: got %h want 000000aa", out_data); end
      checks++; if (out_pc !== 32'h8) begin errors++; $display("FAIL basic_pc: got %h want 00000008", out_pc); end
      checks++; if (out_cycle !== exp_cyc) begin errors++; $display("FAIL basic_cycle: got %0d want %0d", out_cycle, exp_cyc); end
      drive_write(5'd0, 32'h1234, 32'hC);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL x0_no_entry: got valid %0b want 0", out_valid); end
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL x0_level: got %0d want 0", fifo_level); end
   endtask

   task automatic test_mode1();
      out_ready = 1'b0; cfg_mode = 1'b1; cfg_mask = '1;
      drive_write(5'd3, 32'd7, 32'h10);
      drive_write(5'd3, 32'd7, 32'h14);
      drive_write(5'd3, 32'd9, 32'h18);
      checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL mode1_level: got %0d want 2", fifo_level); end
      out_ready = 1'b1;
      checks++; if (out_data !== 32'd7 || out_pc !== 32'h10) begin errors++; $display("FAIL mode1_first: got data %0d pc %h want 7 00000010", out_data, out_pc); end
      @(negedge clk);
      checks++; if (out_data !== 32'd9 || out_pc !== 32'h18) begin errors++; $display("FAIL mode1_second: got data %0d pc %h want 9 00000018", out_data, out_pc); end
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mode1_drained: got valid %0b want 0", out_valid); end
      cfg_mask[3] = 1'b0;
      drive_write(5'd3, 32'h11, 32'h1C);
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL mask_off: got level %0d want 0", fifo_level); end
      cfg_mask[3] = 1'b1;
      // Same value again: no entry proves the masked write still updated the shadow.
      drive_write(5'd3, 32'h11, 32'h20);
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL shadow_updated: got level %0d want 0", fifo_level); end
      drive_write(5'd3, 32'h12, 32'h24);
      checks++; if (fifo_level !== 5'd1 || out_data !== 32'h12) begin errors++; $display("FAIL mode1_change: got level %0d data %h want 1 00000012", fifo_level, out_data); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL mode1_pop: got level %0d want 0", fifo_level); end
   endtask

   task automatic test_overflow();
      cfg_mode = 1'b0; cfg_mask = '1; out_ready = 1'b0;
      for (int i = 0; i < 20; i++) drive_write(5'(1 + i), 32'h100 + 32'(i), 32'h1000 + 32'(4 * i));
      checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d want 16", fifo_level); end
      checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL ovf_drop: got %0d want 4", drop_count); end
      checks++; if (out_data !== 32'h100 || out_pc !== 32'h1000) begin errors++; $display("FAIL ovf_head: got data %h pc %h want 00000100 00001000", out_data, out_pc); end
   endtask

   task automatic test_full_pop();
      logic [31:0] exp_data;
      out_ready = 1'b1;
      wb_en = 1'b1; wb_rd = 5'd21; wb_data = 32'h200; wb_pc = 32'h2000;
      @(negedge clk);
      wb_en = 1'b0; out_ready = 1'b0;
      checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL fullpop_level: got %0d want 16", fifo_level); end
      checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL fullpop_drop: got %0d want 4", drop_count); end
      checks++; if (out_data !== 32'h101) begin errors++; $display("FAIL fullpop_head: got %h want 00000101", out_data); end
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         exp_data = (i < 15) ? 32'h101 + 32'(i) : 32'h200;
         checks++; if (out_valid !== 1'b1 || out_data !== exp_data) begin errors++; $display("FAIL drain_%0d: got valid %0b data %h want 1 %h", i, out_valid, out_data, exp_data); end
         @(negedge clk);
      end
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || fifo_level !== 5'd0) begin errors++; $display("FAIL drain_empty: got valid %0b level %0d want 0 0", out_valid, fifo_level); end
   endtask

   task automatic test_snapshot();
      int n_snap, n_ev, total, ev_pos;
      logic [31:0] exp_data, exp_cyc;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL snap_reset_drop: got %0d want 0", drop_count); end
      cfg_mode = 1'b0; cfg_mask = '0;
      drive_write(5'd0, 32'h1234, 32'h40);
      drive_write(5'd1, 32'd1, 32'h44);
      drive_write(5'd2, 32'd2, 32'h48);
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL snap_masked: got level %0d want 0", fifo_level); end
      cfg_mask = '1; out_ready = 1'b1;
      snap_req = 1'b1;
      @(negedge clk);
      snap_req = 1'b0;
      checks++; if (snap_busy !== 1'b1) begin errors++; $display("FAIL snap_start: got busy %0b want 1", snap_busy); end
      n_snap = 0; n_ev = 0; total = 0; ev_pos = -1; exp_cyc = '0;
      for (int c = 0; c < 200 && n_snap < 32; c++) begin
         wb_en = 1'b0;
         if (out_valid) begin
            if (out_kind) begin
               exp_data = (n_snap == 1) ? 32'd1 : (n_snap == 2) ? 32'd2 : (n_snap == 20) ? 32'h55 : 32'd0;
               checks++; if (out_rd !== 5'(n_snap) || out_data !== exp_data || out_pc !== 32'd0) begin errors++; $display("FAIL snap_entry_%0d: got rd %0d data %h pc %h want %0d %h 0", n_snap, out_rd, out_data, out_pc, n_snap, exp_data); end
               checks++; if (snap_busy !== (n_snap != 31)) begin errors++; $display("FAIL snap_busy_%0d: got %0b want %0b", n_snap, snap_busy, n_snap != 31); end
               if (n_snap == 10) begin
                  wb_en = 1'b1; wb_rd = 5'd20; wb_data = 32'h55; wb_pc = 32'h50;
                  exp_cyc = tb_cyc;
               end
               n_snap++;
            end else begin
               checks++; if (out_rd !== 5'd20 || out_data !== 32'h55 || out_pc !== 32'h50 || out_cycle !== exp_cyc) begin errors++; $display("FAIL snap_event: got rd %0d data %h pc %h cyc %0d want 20 00000055 00000050 %0d", out_rd, out_data, out_pc, out_cycle, exp_cyc); end
               ev_pos = total;
               n_ev++;
            end
            total++;
         end
         @(negedge clk);
      end
      wb_en = 1'b0;
      checks++; if (n_snap !== 32) begin errors++; $display("FAIL snap_count: got %0d want 32", n_snap); end
      checks++; if (n_ev !== 1 || ev_pos !== 11) begin errors++; $display("FAIL snap_interleave: got events %0d at %0d want 1 at 11", n_ev, ev_pos); end
      checks++; if (snap_busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL snap_done: got busy %0b valid %0b want 0 0", snap_busy, out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_dump();
      int n;
      out_ready = 1'b0;
      snap_req = 1'b1;
      @(negedge clk);
      snap_req = 1'b0;
      for (int k = 0; k < 20 && fifo_level != 5'd5; k++) @(negedge clk);
      checks++; if (fifo_level !== 5'd5 || snap_busy !== 1'b1) begin errors++; $display("FAIL middump_setup: got level %0d busy %0b want 5 1", fifo_level, snap_busy); end
      #2 reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL middump_valid: got %0b want 0", out_valid); end
      checks++; if (snap_busy !== 1'b0) begin errors++; $display("FAIL middump_busy: got %0b want 0", snap_busy); end
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL middump_level: got %0d want 0", fifo_level); end
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
      snap_req = 1'b1;
      @(negedge clk);
      snap_req = 1'b0;
      n = 0;
      for (int c = 0; c < 100 && n < 32; c++) begin
         if (out_valid) begin
            checks++; if (out_kind !== 1'b1 || out_rd !== 5'(n) || out_data !== 32'd0) begin errors++; $display("FAIL fresh_dump_%0d: got kind %0b rd %0d data %h want 1 %0d 0", n, out_kind, out_rd, out_data, n); end
            n++;
         end
         @(negedge clk);
      end
      checks++; if (n !== 32 || snap_busy !== 1'b0) begin errors++; $display("FAIL fresh_dump_count: got %0d busy %0b want 32 0", n, snap_busy); end
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mode1();
      test_overflow();
      test_full_pop();
      test_snapshot();
      test_reset_mid_dump();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
